// File: rtl/obs_histogram.sv
// rtl/obs_histogram.sv - observed-count histogram feeding the chi-squared stage
//
// Collects NSAMPLES categorised samples into NBINS saturating bin counters,
// pulses calc_done when the run is complete, then serves one bin count per
// rd_rqst on O_out/data_rdy. A request once all bins have been served ends
// the readout and returns the block to IDLE.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin/restart a collection run (single-cycle pulse)
//   samp_vld, samp_bin  sample strobe and its bin index
//   rd_rqst             request the next bin count
//   O_out, data_rdy     bin count and its one-cycle valid pulse
//   calc_done           one-cycle pulse when the run is complete
//   busy                high while collecting or reading out
//   bad_bin_cnt         saturating count of out-of-range samples
//   ovf                 sticky: some bin saturated during this run
module obs_histogram #(
    parameter int NBINS    = 6,
    parameter int POPSIZE  = 100,
    parameter int NSAMPLES = 65200,
    localparam int CW = $clog2(POPSIZE) + 8,
    localparam int BW = $clog2(NBINS),
    localparam int TW = $clog2(NSAMPLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          samp_vld,
    input  logic [BW-1:0] samp_bin,
    input  logic          rd_rqst,
    output logic [CW-1:0] O_out,
    output logic          data_rdy,
    output logic          calc_done,
    output logic          busy,
    output logic [7:0]    bad_bin_cnt,
    output logic          ovf
);

    localparam int RW = $clog2(NBINS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NBINS];
    logic [CW-1:0]   cnt_d [NBINS];
    logic [TW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [RW-1:0]   rd_idx_q, rd_idx_d;
    logic [CW-1:0]   o_out_q, o_out_d;
    logic            data_rdy_q, data_rdy_d;
    logic            calc_done_q, calc_done_d;
    logic            busy_q, busy_d;
    logic [7:0]      bad_q, bad_d;
    logic            ovf_q, ovf_d;
    logic            clear;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        samp_cnt_d  = samp_cnt_q;
        rd_idx_d    = rd_idx_q;
        o_out_d     = o_out_q;
        data_rdy_d  = 1'b0;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        // start only matters before results are published; it wins over a
        // same-cycle sample so a restart never carries stale data.
        clear       = start && (state_q == IDLE || state_q == COLLECT);

        case (state_q)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (!clear && samp_vld) begin
                    samp_cnt_d = samp_cnt_q + 1'b1;
                    if (int'(samp_bin) < NBINS) begin
                        for (int i = 0; i < NBINS; i++) begin
                            if (int'(samp_bin) == i) begin
                                if (cnt_q[i] == {CW{1'b1}}) ovf_d = 1'b1;
                                else                        cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end else if (bad_q != 8'hff) begin
                        bad_d = bad_q + 8'd1;
                    end
                    if (samp_cnt_q == TW'(NSAMPLES - 1)) state_d = DONE;
                end
            end
            DONE: begin
                rd_idx_d = '0;
                state_d  = READOUT;
            end
            READOUT: begin
                if (rd_rqst) begin
                    if (rd_idx_q < RW'(NBINS)) begin
                        for (int i = 0; i < NBINS; i++) begin
                            if (int'(rd_idx_q) == i) o_out_d = cnt_q[i];
                        end
                        data_rdy_d = 1'b1;
                        rd_idx_d   = rd_idx_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            for (int i = 0; i < NBINS; i++) cnt_d[i] = '0;
            samp_cnt_d = '0;
            bad_d      = '0;
            ovf_d      = 1'b0;
        end

        // Flags are derived from the next state so they line up with it.
        calc_done_d = (state_d == DONE);
        busy_d      = (state_d == COLLECT) || (state_d == READOUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NBINS; i++) cnt_q[i] <= '0;
            samp_cnt_q  <= '0;
            rd_idx_q    <= '0;
            o_out_q     <= '0;
            data_rdy_q  <= 1'b0;
            calc_done_q <= 1'b0;
            busy_q      <= 1'b0;
            bad_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            rd_idx_q    <= rd_idx_d;
            o_out_q     <= o_out_d;
            data_rdy_q  <= data_rdy_d;
            calc_done_q <= calc_done_d;
            busy_q      <= busy_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
        end
    end

    assign O_out       = o_out_q;
    assign data_rdy    = data_rdy_q;
    assign calc_done   = calc_done_q;
    assign busy        = busy_q;
    assign bad_bin_cnt = bad_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_obs_histogram.sv
// tb/tb_obs_histogram.sv - directed vector bench for obs_histogram
module tb_obs_histogram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, samp_vld, rd_rqst;
    logic [2:0]  samp_bin;
    logic [14:0] O_out;
    logic        data_rdy, calc_done, busy, ovf;
    logic [7:0]  bad_bin_cnt;

    logic        s_start, s_vld, s_rd;
    logic [2:0]  s_bin;
    logic [8:0]  s_O_out;
    logic        s_data_rdy, s_calc_done, s_busy, s_ovf;
    logic [7:0]  s_bad;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obs_histogram #(.NBINS(6), .POPSIZE(100), .NSAMPLES(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .samp_vld(samp_vld),
        .samp_bin(samp_bin), .rd_rqst(rd_rqst), .O_out(O_out),
        .data_rdy(data_rdy), .calc_done(calc_done), .busy(busy),
        .bad_bin_cnt(bad_bin_cnt), .ovf(ovf)
    );

    obs_histogram #(.NBINS(6), .POPSIZE(2), .NSAMPLES(600)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .samp_vld(s_vld),
        .samp_bin(s_bin), .rd_rqst(s_rd), .O_out(s_O_out),
        .data_rdy(s_data_rdy), .calc_done(s_calc_done), .busy(s_busy),
        .bad_bin_cnt(s_bad), .ovf(s_ovf)
    );

    typedef struct {
        logic        rst_n, start, vld;
        logic [2:0]  bin;
        logic        rd;
        logic [14:0] o;
        logic        dr, cd, busy;
        logic [7:0]  bad;
        logic        ovf;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic st, input logic vl, input int b,
                     input logic rd, input int o, input logic dr, input logic cd,
                     input logic bz, input int bad, input logic ov);
        vec_t e;
        e.rst_n = r; e.start = st; e.vld = vl; e.bin = 3'(b); e.rd = rd;
        e.o = 15'(o); e.dr = dr; e.cd = cd; e.busy = bz; e.bad = 8'(bad); e.ovf = ov;
        vq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int bins0 [12] = '{0, 0, 1, 2, 2, 2, 3, 4, 4, 5, 5, 5};
    int exp0  [6]  = '{2, 1, 3, 1, 2, 3};
    int bins1 [12] = '{0, 6, 1, 2, 2, 7, 3, 4, 4, 5, 5, 5};
    int bad1  [12] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2};
    int exp1  [6]  = '{1, 1, 2, 1, 2, 3};
    int exp2  [6]  = '{0, 12, 0, 0, 0, 0};
    int exp3  [3]  = '{0, 0, 12};

    initial begin
        int model [6];
        int to;

        // basic run
        v(1,1,0,0,0, 0,0,0,1,0,0);
        for (int i = 0; i < 12; i++) v(1,0,1,bins0[i],0, 0,0,(i==11),(i!=11),0,0);
        v(1,0,0,0,0, 0,0,0,1,0,0);
        for (int i = 0; i < 6; i++) v(1,0,0,0,1, exp0[i],1,0,1,0,0);
        v(1,0,0,0,1, 3,0,0,0,0,0);
        v(1,0,0,0,1, 3,0,0,0,0,0);
        // bad bins, with a stray sample while idle first
        v(1,0,1,7,0, 3,0,0,0,0,0);
        v(1,1,0,0,0, 3,0,0,1,0,0);
        for (int i = 0; i < 12; i++) v(1,0,1,bins1[i],0, 3,0,(i==11),(i!=11),bad1[i],0);
        v(1,0,0,0,0, 3,0,0,1,2,0);
        for (int i = 0; i < 6; i++) v(1,0,0,0,1, exp1[i],1,0,1,2,0);
        v(1,0,0,0,1, 3,0,0,0,2,0);
        // restart mid-collection, then start ignored in readout
        v(1,1,0,0,0, 3,0,0,1,0,0);
        for (int i = 0; i < 5; i++) v(1,0,1,0,0, 3,0,0,1,0,0);
        v(1,1,1,1,0, 3,0,0,1,0,0);
        for (int i = 0; i < 12; i++) v(1,0,1,1,0, 3,0,(i==11),(i!=11),0,0);
        v(1,0,0,0,0, 3,0,0,1,0,0);
        v(1,1,1,0,0, 3,0,0,1,0,0);
        for (int i = 0; i < 6; i++) v(1,0,0,0,1, exp2[i],1,0,1,0,0);
        v(1,0,0,0,1, 0,0,0,0,0,0);
        // reset during readout
        v(1,1,0,0,0, 0,0,0,1,0,0);
        for (int i = 0; i < 12; i++) v(1,0,1,2,0, 0,0,(i==11),(i!=11),0,0);
        v(1,0,0,0,0, 0,0,0,1,0,0);
        for (int i = 0; i < 3; i++) v(1,0,0,0,1, exp3[i],1,0,1,0,0);
        v(0,0,0,0,1, 0,0,0,0,0,0);
        v(1,0,0,0,1, 0,0,0,0,0,0);
        v(1,0,1,3,1, 0,0,0,0,0,0);

        // reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); samp_vld = 1'($urandom);
            samp_bin = 3'($urandom); rd_rqst = 1'($urandom);
            s_start = 1'($urandom); s_vld = 1'($urandom);
            s_bin = 3'($urandom); s_rd = 1'($urandom);
            step();
        end
        chk("rst_O_out", int'(O_out), 0);
        chk("rst_flags", int'({data_rdy, calc_done, busy, ovf}), 0);
        chk("rst_bad_bin_cnt", int'(bad_bin_cnt), 0);
        chk("rst_sat_outputs", int'({s_O_out, s_data_rdy, s_calc_done, s_busy, s_ovf, s_bad}), 0);
        rst_n = 1'b1; start = 0; samp_vld = 0; samp_bin = 0; rd_rqst = 0;
        s_start = 0; s_vld = 0; s_bin = 0; s_rd = 0;
        step();

        // vector table
        foreach (vq[k]) begin
            rst_n = vq[k].rst_n; start = vq[k].start; samp_vld = vq[k].vld;
            samp_bin = vq[k].bin; rd_rqst = vq[k].rd;
            step();
            n_vec++;
            if (O_out !== vq[k].o || data_rdy !== vq[k].dr || calc_done !== vq[k].cd ||
                busy !== vq[k].busy || bad_bin_cnt !== vq[k].bad || ovf !== vq[k].ovf) begin
                n_bad++;
                $display("FAIL vec%0d: got O=%0d dr=%b cd=%b busy=%b bad=%0d ovf=%b expected O=%0d dr=%b cd=%b busy=%b bad=%0d ovf=%b",
                         k, O_out, data_rdy, calc_done, busy, bad_bin_cnt, ovf,
                         vq[k].o, vq[k].dr, vq[k].cd, vq[k].busy, vq[k].bad, vq[k].ovf);
            end
        end
        rst_n = 1; start = 0; samp_vld = 0; rd_rqst = 0;

        // saturation: 600 samples into bin 0 of a 9-bit counter
        s_start = 1; step(); s_start = 0;
        chk("sat_ovf_after_start", int'({s_busy, s_ovf}), 2);
        s_vld = 1; s_bin = 0;
        for (int i = 0; i < 600; i++) step();
        s_vld = 0;
        chk("sat_calc_done", int'(s_calc_done), 1);
        chk("sat_ovf", int'(s_ovf), 1);
        step();
        for (int i = 0; i < 6; i++) begin
            s_rd = 1; step();
            chk($sformatf("sat_bin%0d_rdy", i), int'(s_data_rdy), 1);
            chk($sformatf("sat_bin%0d", i), int'(s_O_out), (i == 0) ? 511 : 0);
        end
        step();
        s_rd = 0;
        chk("sat_end_busy", int'({s_busy, s_data_rdy}), 0);

        // consumer-style integration with random bins
        foreach (model[b]) model[b] = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 12; i++) begin
            samp_vld = 1; samp_bin = 3'($urandom_range(0, 5));
            model[samp_bin]++;
            step();
        end
        samp_vld = 0;
        to = 0;
        while (!calc_done && to < 4) begin step(); to++; end
        chk("int_calc_done", int'(calc_done), 1);
        step();
        for (int i = 0; i < 6; i++) begin
            rd_rqst = 1; step(); rd_rqst = 0;
            to = 0;
            while (!data_rdy && to < 3) begin step(); to++; end
            chk($sformatf("int_rdy%0d", i), int'(data_rdy), 1);
            chk($sformatf("int_bin%0d", i), int'(O_out), model[i]);
        end
        rd_rqst = 1; step(); rd_rqst = 0;
        chk("int_term_no_rdy", int'(data_rdy), 0);
        chk("int_term_busy", int'(busy), 0);
        step();
        chk("int_idle_no_rdy", int'({data_rdy, calc_done}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/obs_histogram.md
Name: obs_histogram

Overview:
- Upstream producer for the chi-squared stage.
- Collects a run of categorised samples into NBINS observed-count bins.
- Signals completion on calc_done, then serves bin counts one at a time on O_out/data_rdy in response to rd_rqst pulses from the chi-squared stage.
- Port widths and handshake match the chi-squared consumer's O_in/data_rdy/calc_done/rd_rqst interface.

Parameters:
- NBINS, 6, number of bins (DoF+1 of the consumer).
- POPSIZE, 100, population scale; sets count width CW = $clog2(POPSIZE)+8.
- NSAMPLES, 65200, valid samples per run; total-counter width is $clog2(NSAMPLES+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin/restart a collection run (single-cycle pulse).
- samp_vld  in  1  sample strobe.
- samp_bin  in  $clog2(NBINS)  bin index of sample.
- rd_rqst  in  1  request next bin count (one request per high cycle).
- O_out  out  CW  observed count for current bin.
- data_rdy  out  1  one-cycle pulse: O_out holds a new bin count.
- calc_done  out  1  one-cycle pulse: collection run complete.
- busy  out  1  high in COLLECT and READOUT.
- bad_bin_cnt  out  8  samples with samp_bin >= NBINS; saturates at 255.
- ovf  out  1  sticky: a bin count saturated this run.

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE. All bin counts, sample counter, rd_idx, O_out, data_rdy, calc_done, busy, bad_bin_cnt and ovf go to 0. Reset overrides every other input, in any state.
- States: IDLE, COLLECT, DONE, READOUT. All outputs are registered.
- IDLE:
  - samp_vld and rd_rqst are ignored.
  - start: clear all bin counts, sample counter, bad_bin_cnt and ovf; next state COLLECT; busy=1 from the next cycle.
- COLLECT:
  - samp_vld with samp_bin < NBINS: that bin increments by 1, saturating at 2^CW-1. A saturating increment sets ovf.
  - samp_vld with samp_bin >= NBINS: bin counts unchanged; bad_bin_cnt increments, saturating at 255.
  - Every samp_vld sample, valid bin or not, increments the sample counter.
  - Update is visible the cycle after acceptance.
  - start while in COLLECT: same clear as from IDLE; stay in COLLECT. A samp_vld in the same cycle is discarded.
  - Sample that brings the counter to NSAMPLES: next state DONE. Later samp_vld is ignored until the next start.
- DONE: calc_done=1 for exactly this one cycle; rd_idx=0; next state READOUT unconditionally.
- READOUT:
  - rd_rqst=1 with rd_idx < NBINS: next cycle O_out = count[rd_idx], data_rdy=1 for that one cycle, rd_idx increments. Latency is 1 cycle from rd_rqst to data_rdy.
  - O_out holds its value until the next served request.
  - rd_rqst=1 with rd_idx == NBINS (the consumer's terminating request): next state IDLE, no data_rdy, busy=0. O_out keeps the last bin count.
  - rd_rqst high on consecutive cycles: each cycle is a separate request.
  - start and samp_vld are ignored.
- calc_done and data_rdy are never high in the same cycle.
- Counts are unsigned; no wrap-around anywhere. All counters saturate or are bounded.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> O_out=0, data_rdy=0, calc_done=0, busy=0, bad_bin_cnt=0, ovf=0.
- Basic run (NSAMPLES=12):
  - Stimulus: start, then samp_bin 0,0,1,2,2,2,3,4,4,5,5,5 on consecutive cycles.
  - calc_done pulses 1 cycle after the 12th sample.
  - Six rd_rqst pulses -> data_rdy 1 cycle after each, O_out = 2,1,3,1,2,3.
  - 7th rd_rqst -> no data_rdy, busy falls next cycle.
- Bad bins (NSAMPLES=12): replace two samples with bins 6 and 7 -> bad_bin_cnt=2; those samples count toward the 12 but add to no bin.
- Saturation (POPSIZE=2, CW=9, NSAMPLES=600): all samples to bin 0 -> O_out for bin 0 = 511, ovf=1, other bins 0.
- Restart: start, 5 samples, start again -> counts cleared; calc_done only after 12 further samples; start during READOUT has no effect.
- Reset mid-readout: rst_n low after 3 bins read -> IDLE, all outputs 0; subsequent rd_rqst gives no data_rdy.
- Integration with chi-squared stage at defaults: after calc_done, the consumer performs exactly six reads and returns to idle; this block returns to IDLE with no extra data_rdy.
